// File: rtl/addsub_pkg.sv
// Shared constants and state encoding for the bit-serial adder-subtractor.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Request/result bundle for serial_addsub_ctrl.
// Optional macro ADDSUB_ZERO_FLAG_EN adds the out_zero result flag.
interface serial_addsub_ctrl_if #(
    parameter int WIDTH = 4
);

    logic             in_start;
    logic             in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_busy;
    logic             out_done;
    logic [WIDTH-1:0] out_result;
    logic             out_co;
    logic             out_ovf;
`ifdef ADDSUB_ZERO_FLAG_EN
    logic             out_zero;

    modport master (
        output in_start, in_op, in_a, in_b,
        input  out_busy, out_done, out_result, out_co, out_ovf, out_zero
    );

    modport slave (
        input  in_start, in_op, in_a, in_b,
        output out_busy, out_done, out_result, out_co, out_ovf, out_zero
    );
`else
    modport master (
        output in_start, in_op, in_a, in_b,
        input  out_busy, out_done, out_result, out_co, out_ovf
    );

    modport slave (
        input  in_start, in_op, in_a, in_b,
        output out_busy, out_done, out_result, out_co, out_ovf
    );
`endif

endinterface

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder cell shared by the serial sequencer.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry of a single bit position.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer around one fa_bit cell, LSB first.
// Optional macro ADDSUB_ZERO_FLAG_EN adds the registered out_zero flag.
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_addsub_ctrl_if.slave   bus
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
`ifdef ADDSUB_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    logic fa_s;
    logic fa_co;

    fa_bit u_fa_bit (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next-state, operand shifting and result capture.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        co_d     = co_q;
        ovf_d    = ovf_q;
`ifdef ADDSUB_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_start) begin
                    state_d = ST_RUN;
                    a_d     = bus.in_a;
                    b_d     = bus.in_b ^ {WIDTH{bus.in_op}};
                    // The operation is carried forward by the inverted B and
                    // the carry seed, so no separate op register is kept.
                    carry_d = (bus.in_op == OP_SUB);
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                // A doubles as the result shadow: each sum bit enters at the
                // MSB as an A bit leaves at the LSB.
                a_d     = {fa_s, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d  = ST_DONE;
                    cnt_d    = '0;
                    result_d = {fa_s, a_q[WIDTH-1:1]};
                    co_d     = fa_co;
                    ovf_d    = carry_q ^ fa_co;
`ifdef ADDSUB_ZERO_FLAG_EN
                    zero_d   = ({fa_s, a_q[WIDTH-1:1]} == '0);
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
`ifdef ADDSUB_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    // Status decode and registered result outputs.
    always_comb begin
        bus.out_busy   = (state_q == ST_RUN) || (state_q == ST_DONE);
        bus.out_done   = (state_q == ST_DONE);
        bus.out_result = result_q;
        bus.out_co     = co_q;
        bus.out_ovf    = ovf_q;
`ifdef ADDSUB_ZERO_FLAG_EN
        bus.out_zero   = zero_q;
`endif
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl (WIDTH=4).
// Honors ADDSUB_ZERO_FLAG_EN when defined.
module tb_serial_addsub_ctrl;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance edge by edge until out_done, counting edges; bounded.
    task automatic wait_done(input string tag, output int edges);
        bit seen;
        seen  = 1'b0;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.out_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_done) cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] er, input logic eco,
                          input logic eovf, input logic ez);
        int e;
        @(negedge clk);
        bus.in_start = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        #1;
        bus.in_start = 1'b0;
        check({tag, "_busy_run"}, 32'(bus.out_busy), 32'd1);
        wait_done(tag, e);
        check({tag, "_latency"}, 32'(e), 32'(WIDTH));
        check({tag, "_result"}, 32'(bus.out_result), 32'(er));
        check({tag, "_co"}, 32'(bus.out_co), 32'(eco));
        check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(eovf));
        check({tag, "_busy_done"}, 32'(bus.out_busy), 32'd1);
`ifdef ADDSUB_ZERO_FLAG_EN
        check({tag, "_zero"}, 32'(bus.out_zero), 32'(ez));
`else
        if (ez) begin end
`endif
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.out_done), 32'd0);
        check({tag, "_busy_idle"}, 32'(bus.out_busy), 32'd0);
        check({tag, "_hold"}, 32'(bus.out_result), 32'(er));
    endtask

    initial begin
        int e;
        int n;

        rst          = 1'b1;
        bus.in_start = 1'b0;
        bus.in_op    = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.out_busy), 32'd0);
        check("rst_done", 32'(bus.out_done), 32'd0);
        check("rst_result", 32'(bus.out_result), 32'd0);
        check("rst_co", 32'(bus.out_co), 32'd0);
        check("rst_ovf", 32'(bus.out_ovf), 32'd0);
`ifdef ADDSUB_ZERO_FLAG_EN
        check("rst_zero", 32'(bus.out_zero), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        //      tag       op    a      b      result co    ovf   zero
        run_op("add3_5",  1'b0, 4'd3,  4'd5,  4'b1000, 1'b0, 1'b1, 1'b0);
        run_op("sub7_2",  1'b1, 4'd7,  4'd2,  4'b0101, 1'b1, 1'b0, 1'b0);
        run_op("sub2_7",  1'b1, 4'd2,  4'd7,  4'b1011, 1'b0, 1'b0, 1'b0);
        run_op("add15_1", 1'b0, 4'd15, 4'd1,  4'b0000, 1'b1, 1'b0, 1'b1);
        run_op("add4_4",  1'b0, 4'd4,  4'd4,  4'b1000, 1'b0, 1'b1, 1'b0);
        run_op("sub8_1",  1'b1, 4'd8,  4'd1,  4'b0111, 1'b1, 1'b1, 1'b0);

        // Start pulse during RUN with different operands must be ignored.
        @(negedge clk);
        bus.in_start = 1'b1;
        bus.in_op    = 1'b0;
        bus.in_a     = 4'd3;
        bus.in_b     = 4'd5;
        @(posedge clk);
        #1;
        bus.in_start = 1'b0;
        @(posedge clk);
        #1;
        bus.in_start = 1'b1;
        bus.in_a     = 4'd1;
        bus.in_b     = 4'd1;
        @(posedge clk);
        #1;
        bus.in_start = 1'b0;
        wait_done("ign", e);
        check("ign_latency", 32'(e), 32'(WIDTH - 2));
        check("ign_result", 32'(bus.out_result), 32'd8);
        @(posedge clk);
        #1;
        check("ign_busy_low", 32'(bus.out_busy), 32'd0);
        count_dones(8, n);
        check("ign_no_second_done", 32'(n), 32'd0);

        // in_start held high: back-to-back ops, operands not resampled in RUN.
        @(negedge clk);
        bus.in_start = 1'b1;
        bus.in_op    = 1'b0;
        bus.in_a     = 4'd1;
        bus.in_b     = 4'd2;
        @(posedge clk);
        #1;
        bus.in_a     = 4'd4;
        bus.in_b     = 4'd4;
        wait_done("hold1", e);
        check("hold1_latency", 32'(e), 32'(WIDTH));
        check("hold1_result", 32'(bus.out_result), 32'd3);
        wait_done("hold2", e);
        bus.in_start = 1'b0;
        check("hold2_spacing", 32'(e), 32'(WIDTH + 2));
        check("hold2_result", 32'(bus.out_result), 32'd8);
        check("hold2_ovf", 32'(bus.out_ovf), 32'd1);
        @(posedge clk);
        #1;
        count_dones(8, n);
        check("hold_stop", 32'(n), 32'd0);

        // Reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        bus.in_start = 1'b1;
        bus.in_op    = 1'b1;
        bus.in_a     = 4'd7;
        bus.in_b     = 4'd2;
        @(posedge clk);
        #1;
        bus.in_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(bus.out_busy), 32'd0);
        check("abort_done", 32'(bus.out_done), 32'd0);
        check("abort_result", 32'(bus.out_result), 32'd0);
        check("abort_co", 32'(bus.out_co), 32'd0);
        check("abort_ovf", 32'(bus.out_ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_dones(8, n);
        check("abort_no_done", 32'(n), 32'd0);
        run_op("after_rst", 1'b0, 4'd1, 4'd1, 4'b0010, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
